// File: rtl/ahb_master_stage.sv
// Per-master AHB-Lite front end: decodes the address phase into a slave request,
// holds it until the target arbiter grants, tracks the data phase and answers unmapped slots.
module ahb_master_stage #(
    parameter logic [15:0] SLAVE_EN = 16'hFFFF
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HMASTLOCK,
    output logic        HREADY,
    output logic        HRESP,
    output logic [15:0] SADDRSEL,
    input  logic [15:0] ADDRGRANT,
    output logic        ADDRPHEND,
    output logic        GATEDHMASTLOCK,
    output logic [31:0] HADDR_H,
    output logic        HWRITE_H,
    output logic [2:0]  HSIZE_H,
    input  logic [15:0] SHREADY,
    input  logic [15:0] SHRESP,
    output logic [3:0]  DATASEL
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state, state_next;
    logic [31:0] haddr_h;
    logic        hwrite_h;
    logic [2:0]  hsize_h;
    logic [3:0]  datasel;
    logic        gated_lock;
    logic        hready;
    logic        hresp;
    logic [15:0] saddrsel;
    logic        addrphend;
    logic [3:0]  held_slave;
    logic [3:0]  new_slave;
    logic        unused_htrans0;

    assign held_slave     = haddr_h[31:28];
    assign new_slave      = HADDR[31:28];
    // Only HTRANS[1] distinguishes a real transfer; SEQ/NONSEQ are treated alike.
    assign unused_htrans0 = HTRANS[0];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        hready     = 1'b1;
        hresp      = 1'b0;
        saddrsel   = '0;
        addrphend  = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_REQ: begin
                hready   = 1'b0;
                saddrsel = 16'd1 << held_slave;
                if (ADDRGRANT[held_slave]) begin
                    addrphend  = 1'b1;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                hready = SHREADY[datasel];
                hresp  = SHRESP[datasel];
            end
            ST_ERR1: begin
                hready     = 1'b0;
                hresp      = 1'b1;
                state_next = ST_ERR2;
            end
            ST_ERR2: hresp = 1'b1;
            default: state_next = ST_IDLE;
        endcase

        // Any cycle that completes towards the master also samples its next address phase.
        if (hready) begin
            if (HTRANS[1])
                state_next = SLAVE_EN[new_slave] ? ST_REQ : ST_ERR1;
            else
                state_next = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            haddr_h    <= '0;
            hwrite_h   <= 1'b0;
            hsize_h    <= '0;
            datasel    <= '0;
            gated_lock <= 1'b0;
        end else begin
            state <= state_next;
            if (hready) begin
                gated_lock <= HMASTLOCK;
                if (HTRANS[1]) begin
                    haddr_h  <= HADDR;
                    hwrite_h <= HWRITE;
                    hsize_h  <= HSIZE;
                end
            end
            if (addrphend)
                datasel <= held_slave;
        end
    end

    assign HREADY         = hready;
    assign HRESP          = hresp;
    assign SADDRSEL       = saddrsel;
    assign ADDRPHEND      = addrphend;
    assign GATEDHMASTLOCK = gated_lock;
    assign HADDR_H        = haddr_h;
    assign HWRITE_H       = hwrite_h;
    assign HSIZE_H        = hsize_h;
    assign DATASEL        = datasel;

endmodule
